move_scheduler: RTL and testbench

Sequences player moves into the board datapath. It detects button presses, arbitrates simultaneous presses, and buffers them in a small queue. It issues one move at a time to the board with a valid/ready/done handshake and produces the one-cycle `active` pulse consumed by the game FSM's step counter. It sits between the synchronized push-button inputs and the board update logic, and is gated by the game FSM's `game_status`.

---
 rtl/game_pkg.sv | 39 +++
 rtl/move_fifo.sv | 73 +++++++
 rtl/move_scheduler.sv | 132 +++++++++++++
 tb/tb_move_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the game datapath: status, move directions, issue FSM states,
// plus the small helpers the move scheduler uses to qualify and arbitrate presses.
package game_pkg;

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } game_status_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_DONE = 2'b10
    } issue_state_e;

    function automatic logic is_playing(input logic [1:0] status);
        return (status == GAMING) || (status == GAME_INITIAL);
    endfunction

    // Button bit index equals its direction code, so the lowest set bit wins.
    function automatic logic [1:0] arb_dir(input logic [3:0] press);
        logic [1:0] dir;
        dir = DIR_RIGHT;
        if (press[0])      dir = DIR_UP;
        else if (press[1]) dir = DIR_DOWN;
        else if (press[2]) dir = DIR_LEFT;
        return dir;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small circular queue of 2-bit moves with synchronous flush; a pop in the same
// cycle frees a slot, so a push into a full queue is accepted when paired with a pop.
module move_fifo #(
    parameter  int QDEPTH = 4,
    localparam int AW     = $clog2(QDEPTH),
    localparam int LW     = AW + 1
) (
    input  logic          clk_d,
    input  logic          rst_n,
    input  logic          push,
    input  logic [1:0]    push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [1:0]    head,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [1:0]    mem_q [QDEPTH];
    logic [1:0]    mem_d [QDEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt_q == LW'(QDEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign head    = mem_q[rd_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk_d) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/move_scheduler.sv
// Turns button edges into queued moves and issues them one at a time to the board
// over valid/ready/done, pulsing active once per move that actually changed tiles.
module move_scheduler
    import game_pkg::*;
#(
    parameter  int QDEPTH = 4,
    localparam int LW     = $clog2(QDEPTH) + 1
) (
    input  logic          clk_d,
    input  logic          rst_n,
    input  logic [3:0]    btn_i,
    input  logic [1:0]    game_status,
    output logic          mv_valid,
    output logic [1:0]    mv_dir,
    input  logic          mv_ready,
    input  logic          mv_done,
    input  logic          mv_moved,
    output logic          active,
    output logic [LW-1:0] q_level,
    output logic          q_overflow
);

    issue_state_e state_q, state_d;
    logic [3:0]   btn_q, btn_d;
    logic         armed_q, armed_d;
    logic [1:0]   mv_dir_q, mv_dir_d;
    logic         active_q, active_d;
    logic         cancel_q, cancel_d;
    logic         ovf_q, ovf_d;

    logic         playing;
    logic [3:0]   press;
    logic         press_vld;
    logic [1:0]   press_dir;
    logic         pop;
    logic [1:0]   head;
    logic         full;
    logic         empty;

    // armed_q blocks the first post-reset cycle so a button held through reset is not a press.
    assign playing   = is_playing(game_status);
    assign press     = btn_i & ~btn_q & {4{playing && armed_q}};
    assign press_vld = |press;
    assign press_dir = arb_dir(press);

    move_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk_d     (clk_d),
        .rst_n     (rst_n),
        .push      (press_vld),
        .push_data (press_dir),
        .pop       (pop),
        .flush     (!playing),
        .head      (head),
        .level     (q_level),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d  = state_q;
        mv_dir_d = mv_dir_q;
        cancel_d = cancel_q;
        active_d = 1'b0;
        pop      = 1'b0;
        btn_d    = btn_i;
        armed_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cancel_d = 1'b0;
                if (!empty && playing) begin
                    pop      = 1'b1;
                    mv_dir_d = head;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A transfer already taken by the board outranks a flush: its done must still be awaited.
                if (mv_ready) begin
                    state_d  = ST_WAIT_DONE;
                    cancel_d = !playing;
                end else if (!playing) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!playing) begin
                    cancel_d = 1'b1;
                end
                if (mv_done) begin
                    active_d = mv_moved && playing && !cancel_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ovf_d = ovf_q;
        if (!playing) begin
            ovf_d = 1'b0;
        end else if (press_vld && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            btn_q    <= 4'b0000;
            armed_q  <= 1'b0;
            mv_dir_q <= DIR_UP;
            active_q <= 1'b0;
            cancel_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_q    <= btn_d;
            armed_q  <= armed_d;
            mv_dir_q <= mv_dir_d;
            active_q <= active_d;
            cancel_q <= cancel_d;
            ovf_q    <= ovf_d;
        end
    end

    assign mv_valid   = (state_q == ST_ISSUE);
    assign mv_dir     = mv_dir_q;
    assign active     = active_q;
    assign q_overflow = ovf_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Randomized and directed bench for move_scheduler, checked every cycle against a
// queue-based reference model of the scheduling rules.
module tb_move_scheduler;

    localparam int QD = 4;
    localparam int LW = $clog2(QD) + 1;

    logic          clk_d = 1'b0;
    logic          rst_n = 1'b1;
    logic [3:0]    btn_i;
    logic [1:0]    game_status;
    logic          mv_valid;
    logic [1:0]    mv_dir;
    logic          mv_ready;
    logic          mv_done;
    logic          mv_moved;
    logic          active;
    logic [LW-1:0] q_level;
    logic          q_overflow;

    always #5 clk_d = ~clk_d;

    move_scheduler #(.QDEPTH(QD)) dut (
        .clk_d       (clk_d),
        .rst_n       (rst_n),
        .btn_i       (btn_i),
        .game_status (game_status),
        .mv_valid    (mv_valid),
        .mv_dir      (mv_dir),
        .mv_ready    (mv_ready),
        .mv_done     (mv_done),
        .mv_moved    (mv_moved),
        .active      (active),
        .q_level     (q_level),
        .q_overflow  (q_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending moves in a queue, the move in flight as a phase
    // (0 none, 1 requesting, 2 awaiting done).
    int       m_q[$];
    bit       m_ovf;
    int       m_phase;
    bit [1:0] m_dir;
    bit       m_cancel;
    bit       m_active;
    bit [3:0] m_prev;
    bit       m_first;

    function automatic void model_reset();
        m_q.delete();
        m_ovf    = 0;
        m_phase  = 0;
        m_dir    = 0;
        m_cancel = 0;
        m_active = 0;
        m_prev   = 0;
        m_first  = 1;
    endfunction

    function automatic void model_step(bit [1:0] gs, bit [3:0] btn, bit rdy, bit done, bit moved);
        bit       playing;
        bit [3:0] press;
        bit       old_cancel;
        int       d;
        playing    = (gs == 2'b01) || (gs == 2'b10);
        old_cancel = m_cancel;
        press      = (m_first || !playing) ? 4'b0000 : (btn & ~m_prev);
        m_active   = 0;
        case (m_phase)
            0: begin
                m_cancel = 0;
                if (playing && m_q.size() > 0) begin
                    m_dir   = 2'(m_q.pop_front());
                    m_phase = 1;
                end
            end
            1: begin
                if (rdy) begin
                    m_phase  = 2;
                    m_cancel = !playing;
                end else if (!playing) begin
                    m_phase = 0;
                end
            end
            default: begin
                if (!playing) m_cancel = 1;
                if (done) begin
                    m_active = moved && playing && !old_cancel;
                    m_phase  = 0;
                end
            end
        endcase
        if (press != 0) begin
            d = 3;
            for (int i = 3; i >= 0; i--) if (press[i]) d = i;
            if (m_q.size() < QD) m_q.push_back(d);
            else m_ovf = 1;
        end
        if (!playing) begin
            m_q.delete();
            m_ovf = 0;
        end
        m_prev  = btn;
        m_first = 0;
    endfunction

    bit chk_en = 0;

    always @(posedge clk_d) begin
        #2;
        if (chk_en) begin
            check("mv_valid", 32'(mv_valid), 32'(m_phase == 1));
            check("mv_dir", 32'(mv_dir), 32'(m_dir));
            check("active", 32'(active), 32'(m_active));
            check("q_level", 32'(q_level), 32'(m_q.size()));
            check("q_overflow", 32'(q_overflow), 32'(m_ovf));
        end
    end

    // Board stand-in and observation bookkeeping
    bit auto_board = 0;
    int rdy_pct    = 100;
    int moved_pct  = 100;
    int spur_pct   = 0;
    int bd_delay   = 1;
    int bd_cnt     = 0;
    int acc_log[$];
    int n_active   = 0;
    int n_valid    = 0;
    int maxlvl     = 0;

    task automatic step();
        if (!rst_n) bd_cnt = 0;
        if (auto_board && rst_n) begin
            mv_ready = ($urandom_range(99) < rdy_pct);
            mv_done  = 1'b0;
            mv_moved = 1'b0;
            if (bd_cnt > 0) begin
                bd_cnt--;
                if (bd_cnt == 0) begin
                    mv_done  = 1'b1;
                    mv_moved = ($urandom_range(99) < moved_pct);
                end
            end else if ($urandom_range(99) < spur_pct) begin
                mv_done  = 1'b1;
                mv_moved = 1'($urandom_range(1));
            end
            if (mv_valid && mv_ready)
                bd_cnt = (bd_delay == 0) ? int'($urandom_range(3, 1)) : bd_delay;
        end
        if (rst_n && mv_valid && mv_ready) acc_log.push_back(int'(mv_dir));
        if (rst_n) model_step(game_status, btn_i, mv_ready, mv_done, mv_moved);
        else model_reset();
        @(negedge clk_d);
        if (active) n_active++;
        if (mv_valid) n_valid++;
        if (int'(q_level) > maxlvl) maxlvl = int'(q_level);
    endtask

    task automatic press_release(input int d);
        btn_i = 4'(1 << d);
        step();
        btn_i = 4'b0000;
        step();
    endtask

    initial begin
        btn_i       = 4'b0000;
        game_status = 2'b01;
        mv_ready    = 1'b0;
        mv_done     = 1'b0;
        mv_moved    = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        chk_en = 1;
        @(negedge clk_d);
        repeat (3) step();
        check("reset_valid", 32'(mv_valid), 0);
        check("reset_dir", 32'(mv_dir), 0);
        check("reset_active", 32'(active), 0);
        check("reset_level", 32'(q_level), 0);
        check("reset_ovf", 32'(q_overflow), 0);
        rst_n = 1'b1;
        repeat (3) step();

        // Single path: right press, ready held, done two cycles after accept
        mv_ready = 1'b1;
        n_active = 0;
        btn_i = 4'b1000;
        step();
        check("single_level_n1", 32'(q_level), 1);
        step();
        check("single_valid_n2", 32'(mv_valid), 1);
        check("single_dir_n2", 32'(mv_dir), 3);
        step();
        check("single_valid_after_accept", 32'(mv_valid), 0);
        step();
        mv_done = 1'b1; mv_moved = 1'b1;
        step();
        check("single_active_m1", 32'(active), 1);
        mv_done = 1'b0; mv_moved = 1'b0;
        step();
        check("single_active_m2", 32'(active), 0);
        btn_i = 4'b0000;
        repeat (4) step();
        check("single_active_count", 32'(n_active), 1);

        // Arbitration: up+left together
        auto_board = 1; rdy_pct = 100; bd_delay = 1; moved_pct = 100; spur_pct = 0;
        acc_log.delete(); maxlvl = 0;
        btn_i = 4'b0101;
        step();
        btn_i = 4'b0000;
        repeat (8) step();
        check("arb_moves", 32'(acc_log.size()), 1);
        if (acc_log.size() > 0) check("arb_dir", 32'(acc_log[0]), 0);
        check("arb_peak_level", 32'(maxlvl), 1);
        check("arb_ovf", 32'(q_overflow), 0);

        // Overflow: board not ready, six presses
        rdy_pct = 0;
        acc_log.delete();
        press_release(3); press_release(1); press_release(2);
        press_release(0); press_release(3); press_release(1);
        check("ovf_level", 32'(q_level), 4);
        check("ovf_flag", 32'(q_overflow), 1);
        check("ovf_held_valid", 32'(mv_valid), 1);
        rdy_pct = 100;
        repeat (30) step();
        check("ovf_issue_count", 32'(acc_log.size()), 5);
        if (acc_log.size() == 5) begin
            check("ovf_order0", 32'(acc_log[0]), 3);
            check("ovf_order1", 32'(acc_log[1]), 1);
            check("ovf_order2", 32'(acc_log[2]), 2);
            check("ovf_order3", 32'(acc_log[3]), 0);
            check("ovf_order4", 32'(acc_log[4]), 3);
        end
        check("ovf_sticky", 32'(q_overflow), 1);

        // Blocked moves: no active, next move still issued
        moved_pct = 0;
        acc_log.delete(); n_active = 0;
        press_release(0); press_release(1);
        repeat (15) step();
        check("blocked_moves", 32'(acc_log.size()), 2);
        check("blocked_active", 32'(n_active), 0);

        // Flush while awaiting done
        moved_pct = 100; bd_delay = 12;
        press_release(0); press_release(1); press_release(2); press_release(3);
        check("flush_queued", 32'(q_level), 3);
        check("flush_in_wait", 32'(mv_valid), 0);
        game_status = 2'b11;
        n_active = 0; n_valid = 0;
        repeat (20) step();
        check("flush_active", 32'(n_active), 0);
        check("flush_valid", 32'(n_valid), 0);
        check("flush_level", 32'(q_level), 0);
        check("flush_ovf", 32'(q_overflow), 0);
        game_status = 2'b01; bd_delay = 1;
        repeat (4) step();

        // Async reset during ISSUE with a button held through it
        rdy_pct = 0;
        btn_i = 4'b0010; step();
        btn_i = 4'b0000; step();
        btn_i = 4'b0001; step();
        step();
        check("rst_pre_valid", 32'(mv_valid), 1);
        check("rst_pre_level", 32'(q_level), 1);
        #1 rst_n = 1'b0;
        model_reset();
        bd_cnt = 0;
        #1;
        check("rst_async_valid", 32'(mv_valid), 0);
        check("rst_async_level", 32'(q_level), 0);
        check("rst_async_active", 32'(active), 0);
        repeat (2) step();
        rst_n = 1'b1; rdy_pct = 100; n_valid = 0;
        repeat (6) step();
        check("rst_held_no_valid", 32'(n_valid), 0);
        check("rst_held_level", 32'(q_level), 0);
        btn_i = 4'b0000; step();
        btn_i = 4'b0001; step();
        check("rst_repress_level", 32'(q_level), 1);
        btn_i = 4'b0000;
        repeat (6) step();

        // Randomized traffic
        rdy_pct = 60; bd_delay = 0; moved_pct = 70; spur_pct = 5;
        for (int i = 0; i < 3000; i++) begin
            rst_n = 1'b1;
            if ($urandom_range(999) == 0) rst_n = 1'b0;
            if ($urandom_range(99) < 3) begin
                if ($urandom_range(99) < 70) game_status = ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
                else game_status = ($urandom_range(1) == 0) ? 2'b00 : 2'b11;
            end
            for (int b = 0; b < 4; b++)
                if ($urandom_range(99) < 15) btn_i[b] = ~btn_i[b];
            step();
        end
        rst_n = 1'b1;
        step();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
